// File: rtl/spi_master_pkg.sv
// Shared types and constants for the ADXL355 SPI master.
// Contents: FSM state enum, R/W command-bit encodings, byte width, and a
// helper that forms the command byte {addr[6:0], R/W}.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    DATA,
    CS_HOLD,
    CS_IDLE
  } spi_state_t;

  localparam logic CMD_READ      = 1'b1;
  localparam logic CMD_WRITE     = 1'b0;
  localparam int   BITS_PER_BYTE = 8;

  function automatic logic [7:0] cmd_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for SPI mode 0.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   en        - run the divider; while low the counter sits at 0 and sclk is low
//   sclk      - registered serial clock, low for the first half of each bit
//   rise_stb  - high during the first clk cycle in which sclk is high
//   fall_stb  - high during the last clk cycle of a bit (sclk falls at its end)
module spi_sclk_gen #(
  parameter int CLK_DIV = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int HALF_DIV = CLK_DIV / 2;
  localparam int CNT_W    = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sclk_reg;

  always_comb begin
    cnt_next = (cnt_reg == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_reg + CNT_W'(1);
  end

  // sclk_reg is computed from the next count so that it lines up with
  // cnt_reg in the same cycle: low for counts 0..HALF-1, high for HALF..DIV-1.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      sclk_reg <= (cnt_next >= CNT_W'(HALF_DIV));
    end
  end

  assign sclk     = sclk_reg;
  assign rise_stb = en && (cnt_reg == CNT_W'(HALF_DIV));
  assign fall_stb = en && (cnt_reg == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master (mode 0, MSB first) for the ADXL355 register port.
// A transaction is a command byte {addr, R/W} followed by one or more data
// bytes; send_start held high at a byte boundary continues a burst.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   miso              - serial data from the slave
//   wr_rd             - 1 = read, 0 = write (latched at transaction start)
//   spi_addr_master   - 7-bit register address (latched at transaction start)
//   spi_data_master   - write data (latched at the start of each data byte)
//   send_start        - start request in IDLE, burst-continue at byte boundaries
//   data_out_vld      - one-cycle strobe when a read byte is complete
//   data_out          - last received read byte
//   cs_n, sclk, mosi  - SPI pins
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  input  logic       wr_rd,
  input  logic [6:0] spi_addr_master,
  input  logic [7:0] spi_data_master,
  input  logic       send_start,
  output logic       data_out_vld,
  output logic [7:0] data_out,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi
);

  localparam int HALF_DIV = CLK_DIV / 2;
  localparam int H_W      = $clog2(HALF_DIV) + 1;

  spi_state_t     state_reg;
  logic [H_W-1:0] half_cnt_reg;
  logic [2:0]     bit_cnt_reg;
  logic [7:0]     tx_sr_reg;
  logic [7:0]     rx_sr_reg;
  logic           rd_reg;
  logic           cs_n_reg;
  logic           mosi_reg;
  logic [7:0]     data_out_reg;
  logic           vld_reg;

  logic sclk_en;
  logic rise_stb;
  logic fall_stb;
  logic half_last;
  logic byte_last;

  assign sclk_en   = (state_reg == CMD) || (state_reg == DATA);
  assign half_last = (half_cnt_reg == H_W'(HALF_DIV - 1));
  assign byte_last = (bit_cnt_reg == 3'(BITS_PER_BYTE - 1));

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      rd_reg       <= 1'b0;
      cs_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      data_out_reg <= '0;
      vld_reg      <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cs_n_reg <= 1'b1;
          mosi_reg <= 1'b0;
          if (send_start) begin
            rd_reg       <= wr_rd;
            tx_sr_reg    <= cmd_byte(spi_addr_master, wr_rd);
            mosi_reg     <= spi_addr_master[6];  // command bit 7 shown during setup
            cs_n_reg     <= 1'b0;
            half_cnt_reg <= '0;
            state_reg    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= CMD;
          end else begin
            half_cnt_reg <= half_cnt_reg + H_W'(1);
          end
        end
        CMD: begin
          if (fall_stb) begin
            if (byte_last) begin
              bit_cnt_reg <= '0;
              state_reg   <= DATA;
              tx_sr_reg   <= (rd_reg == CMD_WRITE) ? spi_data_master : 8'h00;
              mosi_reg    <= (rd_reg == CMD_WRITE) ? spi_data_master[7] : 1'b0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_sr_reg   <= {tx_sr_reg[6:0], 1'b0};
              mosi_reg    <= tx_sr_reg[6];
            end
          end
        end
        DATA: begin
          if (rise_stb) begin
            rx_sr_reg <= {rx_sr_reg[6:0], miso};
            if (byte_last && rd_reg == CMD_READ) begin
              data_out_reg <= {rx_sr_reg[6:0], miso};
              vld_reg      <= 1'b1;
            end
          end
          if (fall_stb) begin
            if (byte_last) begin
              bit_cnt_reg <= '0;
              if (send_start) begin
                // Burst: the slave auto-increments, so just load the next byte.
                tx_sr_reg <= (rd_reg == CMD_WRITE) ? spi_data_master : 8'h00;
                mosi_reg  <= (rd_reg == CMD_WRITE) ? spi_data_master[7] : 1'b0;
              end else begin
                half_cnt_reg <= '0;
                mosi_reg     <= 1'b0;
                state_reg    <= CS_HOLD;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_sr_reg   <= {tx_sr_reg[6:0], 1'b0};
              mosi_reg    <= tx_sr_reg[6];
            end
          end
        end
        CS_HOLD: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            cs_n_reg     <= 1'b1;
            state_reg    <= CS_IDLE;
          end else begin
            half_cnt_reg <= half_cnt_reg + H_W'(1);
          end
        end
        CS_IDLE: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            half_cnt_reg <= half_cnt_reg + H_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cs_n         = cs_n_reg;
  assign mosi         = mosi_reg;
  assign data_out     = data_out_reg;
  assign data_out_vld = vld_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a negedge monitor decodes mosi bytes, times
// sclk rises, cs_n windows and data_out_vld pulses, and acts as a mode-0
// slave that drives miso from a per-transaction byte table.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       miso;
  logic       wr_rd;
  logic [6:0] spi_addr_master;
  logic [7:0] spi_data_master;
  logic       send_start;
  logic       data_out_vld;
  logic [7:0] data_out;
  logic       cs_n;
  logic       sclk;
  logic       mosi;

  int vectors = 0;
  int miscompares = 0;

  // monitor / slave state
  int         cyc = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs_n = 1'b1;
  int         cs_windows = 0;
  int         cs_low_cnt = 0;
  int         cs_low_last = 0;
  int         rise_cnt = 0;
  int         total_rises = 0;
  int         last_rise = 0;
  int         period_err = 0;
  int         vld_cnt = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic [7:0] mosi_bytes [0:15];
  int         rise_cyc [0:63];
  logic [7:0] vld_data [0:7];
  int         vld_cyc [0:7];
  logic [7:0] miso_bytes [0:7];
  logic       slave_miso = 1'b0;
  logic       idle_toggle = 1'b0;

  assign miso = slave_miso ^ idle_toggle;

  always #10 clk = ~clk;

  spi_master #(.CLK_DIV(40)) dut (
    .clk             (clk),
    .rst             (rst),
    .miso            (miso),
    .wr_rd           (wr_rd),
    .spi_addr_master (spi_addr_master),
    .spi_data_master (spi_data_master),
    .send_start      (send_start),
    .data_out_vld    (data_out_vld),
    .data_out        (data_out),
    .cs_n            (cs_n),
    .sclk            (sclk),
    .mosi            (mosi)
  );

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= sclk;
    prev_cs_n <= cs_n;
    if (prev_cs_n === 1'b1 && cs_n === 1'b0) begin
      cs_windows <= cs_windows + 1;
      cs_low_cnt <= 1;
      rise_cnt   <= 0;
      vld_cnt    <= 0;
      period_err <= 0;
      slave_miso <= miso_bytes[0][7];
    end else if (cs_n === 1'b0) begin
      cs_low_cnt <= cs_low_cnt + 1;
    end
    if (prev_cs_n === 1'b0 && cs_n === 1'b1) cs_low_last <= cs_low_cnt;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      total_rises <= total_rises + 1;
      rise_cnt    <= rise_cnt + 1;
      last_rise   <= cyc;
      if (rise_cnt < 64) rise_cyc[rise_cnt] <= cyc;
      if (rise_cnt > 0 && (cyc - last_rise) != 40) period_err <= period_err + 1;
      mosi_sr <= {mosi_sr[6:0], mosi};
      if (rise_cnt % 8 == 7 && rise_cnt < 128) mosi_bytes[rise_cnt / 8] <= {mosi_sr[6:0], mosi};
    end
    if (sclk === 1'b0 && prev_sclk === 1'b1 && rise_cnt < 64)
      slave_miso <= miso_bytes[rise_cnt / 8][7 - (rise_cnt % 8)];
    if (data_out_vld === 1'b1 && vld_cnt < 8) begin
      vld_data[vld_cnt] <= data_out;
      vld_cyc[vld_cnt]  <= cyc;
      vld_cnt           <= vld_cnt + 1;
    end
  end

  task automatic start_txn(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input bit hold);
    @(negedge clk);
    wr_rd           = rw;
    spi_addr_master = addr;
    spi_data_master = data;
    send_start      = 1'b1;
    if (!hold) begin
      @(negedge clk);
      send_start = 1'b0;
    end
  endtask

  // Waits for a cs_n low window that began after w0 to close, then lets the
  // FSM walk through CS_IDLE back to IDLE.
  task automatic wait_done(input int w0);
    int i;
    for (i = 0; i < 200 && cs_windows == w0; i++) @(negedge clk);
    if (cs_windows == w0) begin
      vectors++; miscompares++;
      $display("FAIL wait_cs_fall: timed out, cs_n = %b, required a low window", cs_n);
    end
    for (i = 0; i < 4000 && cs_n !== 1'b1; i++) @(negedge clk);
    if (cs_n !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_cs_rise: timed out, cs_n = %b, required 1", cs_n);
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    if (data_out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b want 0", data_out_vld); end
    $display("txn reset: cs_n=%b sclk=%b mosi=%b data_out=%h", cs_n, sclk, mosi, data_out);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int r0, w0, bad;
    r0 = total_rises; w0 = cs_windows; bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      idle_toggle = ~idle_toggle;
      if (cs_n !== 1'b1 || sclk !== 1'b0) bad++;
    end
    idle_toggle = 1'b0;
    vectors += 4;
    if (bad != 0) begin miscompares++; $display("FAIL idle_pins: %0d cycles with cs_n/sclk active, want 0", bad); end
    if (total_rises != r0) begin miscompares++; $display("FAIL idle_rises: got %0d want 0", total_rises - r0); end
    if (cs_windows != w0) begin miscompares++; $display("FAIL idle_cs: got %0d windows want 0", cs_windows - w0); end
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL idle_data_out: got %h want 00", data_out); end
    $display("txn idle: 300 cycles, data_out=%h", data_out);
  endtask

  task automatic test_write_single();
    int w0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    w0 = cs_windows;
    start_txn(1'b0, 7'h01, 8'h33, 1'b0);
    wait_done(w0);
    vectors += 7;
    if (mosi_bytes[0] !== 8'h02) begin miscompares++; $display("FAIL wr_cmd: got %h want 02", mosi_bytes[0]); end
    if (mosi_bytes[1] !== 8'h33) begin miscompares++; $display("FAIL wr_data: got %h want 33", mosi_bytes[1]); end
    if (rise_cnt != 16) begin miscompares++; $display("FAIL wr_rises: got %0d want 16", rise_cnt); end
    if (cs_low_last != 680) begin miscompares++; $display("FAIL wr_cs_low: got %0d want 680", cs_low_last); end
    if (period_err != 0) begin miscompares++; $display("FAIL wr_period: %0d bad periods want 0", period_err); end
    if (vld_cnt != 0) begin miscompares++; $display("FAIL wr_vld: got %0d pulses want 0", vld_cnt); end
    if (cs_windows != w0 + 1) begin miscompares++; $display("FAIL wr_windows: got %0d want 1", cs_windows - w0); end
    $display("txn write_single: cmd=%h data=%h rises=%0d cs_low=%0d", mosi_bytes[0], mosi_bytes[1], rise_cnt, cs_low_last);
  endtask

  task automatic test_read_single();
    int w0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    miso_bytes[1] = 8'hA5;
    w0 = cs_windows;
    start_txn(1'b1, 7'h01, 8'hFF, 1'b0);
    wait_done(w0);
    vectors += 6;
    if (mosi_bytes[0] !== 8'h03) begin miscompares++; $display("FAIL rd_cmd: got %h want 03", mosi_bytes[0]); end
    if (mosi_bytes[1] !== 8'h00) begin miscompares++; $display("FAIL rd_mosi_data: got %h want 00", mosi_bytes[1]); end
    if (vld_cnt != 1) begin miscompares++; $display("FAIL rd_vld_count: got %0d want 1", vld_cnt); end
    if (vld_data[0] !== 8'hA5) begin miscompares++; $display("FAIL rd_vld_data: got %h want a5", vld_data[0]); end
    if (vld_cyc[0] - rise_cyc[15] != 1) begin miscompares++; $display("FAIL rd_vld_time: got %0d cycles after rise 16 want 1", vld_cyc[0] - rise_cyc[15]); end
    if (data_out !== 8'hA5) begin miscompares++; $display("FAIL rd_data_out_held: got %h want a5", data_out); end
    $display("txn read_single: cmd=%h data_out=%h vld=%0d", mosi_bytes[0], data_out, vld_cnt);
  endtask

  // send_start goes high at the edge that leaves IDLE (E0). Data byte k is
  // latched at E0+340+320k; inputs change mid-byte, and send_start drops in
  // the fourth data byte so it is the last.
  task automatic burst(input logic rw, input logic [6:0] addr);
    start_txn(rw, addr, 8'h00, 1'b1);
    repeat (500) @(negedge clk);
    spi_data_master = 8'h01;
    repeat (320) @(negedge clk);
    spi_data_master = 8'h02;
    repeat (320) @(negedge clk);
    spi_data_master = 8'h03;
    repeat (320) @(negedge clk);
    send_start = 1'b0;
  endtask

  task automatic test_burst_write();
    int w0;
    logic [7:0] exp [0:4];
    exp[0] = 8'h04; exp[1] = 8'h00; exp[2] = 8'h01; exp[3] = 8'h02; exp[4] = 8'h03;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    w0 = cs_windows;
    burst(1'b0, 7'h02);
    wait_done(w0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (mosi_bytes[i] !== exp[i]) begin miscompares++; $display("FAIL bw_byte%0d: got %h want %h", i, mosi_bytes[i], exp[i]); end
    end
    vectors += 5;
    if (rise_cnt != 40) begin miscompares++; $display("FAIL bw_rises: got %0d want 40", rise_cnt); end
    if (cs_low_last != 1640) begin miscompares++; $display("FAIL bw_cs_low: got %0d want 1640", cs_low_last); end
    if (cs_windows != w0 + 1) begin miscompares++; $display("FAIL bw_windows: got %0d want 1", cs_windows - w0); end
    if (vld_cnt != 0) begin miscompares++; $display("FAIL bw_vld: got %0d pulses want 0", vld_cnt); end
    if (period_err != 0) begin miscompares++; $display("FAIL bw_period: %0d bad periods want 0", period_err); end
    $display("txn burst_write: %h %h %h %h %h rises=%0d", mosi_bytes[0], mosi_bytes[1], mosi_bytes[2], mosi_bytes[3], mosi_bytes[4], rise_cnt);
  endtask

  task automatic test_burst_read();
    int w0;
    logic [7:0] exp [0:3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    for (int i = 0; i < 4; i++) miso_bytes[i + 1] = exp[i];
    w0 = cs_windows;
    burst(1'b1, 7'h02);
    wait_done(w0);
    vectors += 2;
    if (mosi_bytes[0] !== 8'h05) begin miscompares++; $display("FAIL br_cmd: got %h want 05", mosi_bytes[0]); end
    if (vld_cnt != 4) begin miscompares++; $display("FAIL br_vld_count: got %0d want 4", vld_cnt); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (vld_data[i] !== exp[i]) begin miscompares++; $display("FAIL br_data%0d: got %h want %h", i, vld_data[i], exp[i]); end
      if (i > 0) begin
        vectors++;
        if (vld_cyc[i] - vld_cyc[i-1] != 320) begin miscompares++; $display("FAIL br_spacing%0d: got %0d want 320", i, vld_cyc[i] - vld_cyc[i-1]); end
      end
    end
    $display("txn burst_read: %h %h %h %h vld=%0d", vld_data[0], vld_data[1], vld_data[2], vld_data[3], vld_cnt);
  endtask

  task automatic test_reset_mid_cmd();
    int w0, r0, i;
    for (int k = 0; k < 8; k++) miso_bytes[k] = 8'h00;
    w0 = cs_windows;
    start_txn(1'b0, 7'h55, 8'hC3, 1'b0);
    for (i = 0; i < 400 && !(cs_windows != w0 && rise_cnt >= 3); i++) @(negedge clk);
    vectors++;
    if (!(cs_windows != w0 && rise_cnt >= 3)) begin
      miscompares++; $display("FAIL rm_reach_bit3: timed out, rises=%0d want 3", rise_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors += 5;
    if (cs_n !== 1'b1) begin miscompares++; $display("FAIL rm_cs_n: got %b want 1", cs_n); end
    if (sclk !== 1'b0) begin miscompares++; $display("FAIL rm_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin miscompares++; $display("FAIL rm_mosi: got %b want 0", mosi); end
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL rm_data_out: got %h want 00", data_out); end
    if (data_out_vld !== 1'b0) begin miscompares++; $display("FAIL rm_vld: got %b want 0", data_out_vld); end
    $display("txn reset_mid_cmd: cs_n=%b sclk=%b mosi=%b", cs_n, sclk, mosi);
    rst = 1'b0;
    r0 = total_rises;
    repeat (100) @(negedge clk);
    vectors++;
    if (total_rises != r0) begin miscompares++; $display("FAIL rm_no_edges: got %0d rises want 0", total_rises - r0); end
    w0 = cs_windows;
    start_txn(1'b0, 7'h0A, 8'h5A, 1'b0);
    wait_done(w0);
    vectors += 4;
    if (mosi_bytes[0] !== 8'h14) begin miscompares++; $display("FAIL rm_new_cmd: got %h want 14", mosi_bytes[0]); end
    if (mosi_bytes[1] !== 8'h5A) begin miscompares++; $display("FAIL rm_new_data: got %h want 5a", mosi_bytes[1]); end
    if (rise_cnt != 16) begin miscompares++; $display("FAIL rm_new_rises: got %0d want 16", rise_cnt); end
    if (cs_low_last != 680) begin miscompares++; $display("FAIL rm_new_cs_low: got %0d want 680", cs_low_last); end
    $display("txn after_reset_write: cmd=%h data=%h", mosi_bytes[0], mosi_bytes[1]);
  endtask

  initial begin
    rst             = 1'b1;
    wr_rd           = 1'b0;
    spi_addr_master = 7'h00;
    spi_data_master = 8'h00;
    send_start      = 1'b0;
    for (int i = 0; i < 8; i++) miso_bytes[i] = 8'h00;
    for (int i = 0; i < 16; i++) mosi_bytes[i] = 8'h00;
    test_reset();
    test_idle();
    test_write_single();
    test_read_single();
    test_burst_write();
    test_burst_read();
    test_reset_mid_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Byte-oriented SPI master for the ADXL355 accelerometer register interface, in SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- A transaction is one command byte {addr[6:0], R/W} followed by one or more data bytes.
- For reads, each received byte is presented on a parallel output with a valid strobe.
- The block sits between the sensor-control FSM and the device pins.

Parameters:
- CLK_DIV, 40: system clocks per SCLK period. Must be even and ≥4. 50 MHz / 40 = 1.25 MHz SCLK.
- HALF_DIV, CLK_DIV/2: derived. System clocks per SCLK phase; also the CS setup, CS hold and CS idle time.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: reset, synchronous, active-high.
- miso, input, 1: serial data from slave.
- wr_rd, input, 1: 1 = read, 0 = write. Sampled at transaction start.
- spi_addr_master, input, 7: register address. Sampled at transaction start.
- spi_data_master, input, 8: write data. Sampled at the start of each data byte.
- send_start, input, 1: request/continue level (see Behaviour).
- data_out_vld, output, 1: one-cycle strobe; a read byte is complete.
- data_out, output, 8: last received read byte. Held until the next strobe.
- cs_n, output, 1: chip select, active low.
- sclk, output, 1: serial clock, idles low.
- mosi, output, 1: serial data to slave.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - cs_n=1, sclk=0, mosi=0, data_out=0, data_out_vld=0.
  - FSM goes to IDLE; all counters are cleared.
  - Reset mid-transaction aborts it immediately, with no further SCLK edges.
- FSM states: IDLE → CS_SETUP → CMD → DATA → (DATA…) → CS_HOLD → CS_IDLE → IDLE.
- IDLE:
  - cs_n=1, sclk=0.
  - If send_start=1, latch wr_rd and spi_addr_master.
  - Form the command byte {spi_addr_master[6:0], wr_rd}; read sets the LSB to 1.
  - Go to CS_SETUP.
- CS_SETUP:
  - cs_n=0 for HALF_DIV clocks.
  - mosi is driven with command bit 7 during this state.
- Bit timing (CMD and DATA), each bit = CLK_DIV clocks:
  - sclk is low for the first HALF_DIV clocks and high for the second HALF_DIV clocks.
  - mosi changes only on the sclk falling edge, or on the CS_SETUP → first-bit boundary.
  - miso is sampled on the clk cycle of the sclk rising edge.
- CMD: 8 bits, MSB first; 320 clocks.
- DATA:
  - At the start of each data byte (write), spi_data_master is latched into the shift register.
  - In read mode, mosi=0 for the whole data phase.
  - Each data byte is 8 bits, MSB first.
  - Read: after the 8th rising-edge sample, data_out ← shifted byte and data_out_vld=1 for exactly one clk.
  - Write: data_out_vld stays 0 throughout.
- Byte boundary, end of a DATA byte's 8th bit (sclk back low):
  - If send_start=1, start another DATA byte (burst); the slave auto-increments the address.
  - If send_start=0, go to CS_HOLD.
- Single access: drop send_start during the first data byte. The command is still always followed by at least one data byte.
- CS_HOLD: sclk=0, cs_n=0 for HALF_DIV clocks, then cs_n=1.
- CS_IDLE: cs_n=1 for HALF_DIV clocks. send_start is ignored here, then go to IDLE.
- send_start while busy is not a new request; only the byte-boundary check uses it.
- wr_rd and spi_addr_master changes mid-transaction have no effect.
- Single-byte transaction total: 20 + 640 + 20 + 20 = 700 clocks from the IDLE exit to the return to IDLE. Each added burst byte adds 320 clocks.

Decomposition:
- Package spi_master_pkg:
  - FSM state enum: IDLE, CS_SETUP, CMD, DATA, CS_HOLD, CS_IDLE.
  - Constants: CMD_READ=1'b1, CMD_WRITE=1'b0, BITS_PER_BYTE=8.
- One natural sub-module, spi_sclk_gen:
  - A divider counter producing sclk plus one-cycle rise_stb and fall_stb strobes.
  - Enabled only in CMD and DATA.
- The top module holds the FSM, the bit counter, and the TX/RX shift registers.

Test Plan:
- Write single: addr 0x01, data 0x33, send_start pulsed for 1 clk → mosi shows 0x02 then 0x33. cs_n low for 680 clocks. 16 sclk rises, sclk period 40 clk. data_out_vld never asserted.
- Read single: addr 0x01, slave drives miso=0xA5 (mode 0) → mosi command 0x03. data_out=0xA5 with exactly one data_out_vld pulse after the 16th sclk rise.
- Burst write: addr 0x02, send_start held ~4×320 clk, data changed each byte 0x00–0x03 → 5 bytes on mosi (0x04, 0x00, 0x01, 0x02, 0x03). One contiguous cs_n low window.
- Burst read: addr 0x02, 4 bytes, miso 0x11/0x22/0x33/0x44 → 4 vld pulses with those values, 320 clocks apart.
- Reset mid-CMD (rst=1 at bit 3) → next clk: cs_n=1, sclk=0, mosi=0. A new send_start afterwards performs a clean transaction.
- Idle after reset: send_start=0 → cs_n stays 1 and sclk stays 0 indefinitely. A toggle on miso has no effect on data_out.
